// File: rtl/pim_seq_pkg.sv
// Shared state type, opcode/base constants and micro-word bit positions
// for the PIM microcode sequencer and its address map.
package pim_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

    localparam logic [3:0] OP_JLD4_A = 4'h6;
    localparam logic [3:0] OP_JLD4_B = 4'h7;
    localparam logic [3:0] OP_JLD5_A = 4'h8;
    localparam logic [3:0] OP_JLD5_B = 4'h9;

    localparam logic [15:0] BASE_JLD4_A = 16'd6;
    localparam logic [15:0] BASE_JLD4_B = 16'd38;
    localparam logic [15:0] BASE_JLD5_A = 16'd54;
    localparam logic [15:0] BASE_JLD5_B = 16'd86;

    localparam int UWORD_W_DEF = 32;
    localparam int EOR_BIT     = UWORD_W_DEF - 1;
    localparam int WAIT_BIT    = UWORD_W_DEF - 2;

endpackage

// File: rtl/uaddr_map.sv
// Combinational opcode/function-field to microcode entry address map.
module uaddr_map
    import pim_seq_pkg::*;
#(
    parameter int UADDR_W = 16
) (
    input  logic [3:0]         opcode,
    input  logic [3:0]         function4bit,
    input  logic [4:0]         function5bit,
    output logic [UADDR_W-1:0] uaddr
);

    // NOTE: every path assigns uaddr, so this block cannot infer a latch.
    always_comb begin
        case (opcode)
            OP_JLD4_A: uaddr = UADDR_W'(BASE_JLD4_A) + UADDR_W'(function4bit);
            OP_JLD4_B: uaddr = UADDR_W'(BASE_JLD4_B) + UADDR_W'(function4bit);
            OP_JLD5_A: uaddr = UADDR_W'(BASE_JLD5_A) + UADDR_W'(function5bit);
            OP_JLD5_B: uaddr = UADDR_W'(BASE_JLD5_B) + UADDR_W'(function5bit);
            default:   uaddr = UADDR_W'(opcode);
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Walks a microcode routine from the mapped entry address, issuing one
// control word per ROM entry until the end-of-routine bit.
module microcode_sequencer
    import pim_seq_pkg::*;
#(
    parameter int UADDR_W = 16,
    parameter int UWORD_W = UWORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [3:0]         opcode,
    input  logic [3:0]         function4bit,
    input  logic [4:0]         function5bit,
    output logic [UADDR_W-1:0] rom_addr,
    input  logic [UWORD_W-1:0] rom_data,
    output logic               ctrl_valid,
    input  logic               ctrl_ready,
    output logic [UWORD_W-3:0] ctrl_word,
    input  logic               array_done,
    input  logic               flush,
    output logic               busy,
    output logic               instr_done
);

    // Control bits keep their offset from the MSB whatever the word width.
    localparam int EorPos  = UWORD_W - UWORD_W_DEF + EOR_BIT;
    localparam int WaitPos = UWORD_W - UWORD_W_DEF + WAIT_BIT;

    seq_state_t         state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [UWORD_W-1:0] uword_q, uword_d;
    logic               ctrl_valid_q, ctrl_valid_d;
    logic               busy_q, busy_d;
    logic               instr_done_q, instr_done_d;
    logic [UADDR_W-1:0] entry_addr;
    logic               retire;

    uaddr_map #(.UADDR_W(UADDR_W)) u_uaddr_map (
        .opcode       (opcode),
        .function4bit (function4bit),
        .function5bit (function5bit),
        .uaddr        (entry_addr)
    );

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        uword_d = uword_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    upc_d   = entry_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                uword_d = rom_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (ctrl_ready) begin
                    if (uword_q[WaitPos] && !array_done) state_d = WAIT;
                    else                                 retire  = 1'b1;
                end
            end
            WAIT:    retire  = array_done;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The word is finished: end the routine or step to the next entry.
        if (retire) begin
            if (uword_q[EorPos]) begin
                state_d = DONE;
            end else begin
                upc_d   = upc_q + UADDR_W'(1);
                state_d = FETCH;
            end
        end

        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            upc_d   = upc_q;
        end

        ctrl_valid_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        instr_done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            upc_q        <= '0;
            uword_q      <= '0;
            ctrl_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            upc_q        <= upc_d;
            uword_q      <= uword_d;
            ctrl_valid_q <= ctrl_valid_d;
            busy_q       <= busy_d;
            instr_done_q <= instr_done_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign rom_addr    = upc_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign ctrl_word   = uword_q[UWORD_W-3:0];
    assign busy        = busy_q;
    assign instr_done  = instr_done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench: ROM model plus a scoreboard of expected control words
// (address and payload) popped on every control handshake.
module tb_microcode_sequencer;
    import pim_seq_pkg::*;

    localparam int UA = 8;   // narrow address so the wrap case stays short
    localparam int UW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [3:0]    function4bit;
    logic [4:0]    function5bit;
    logic [UA-1:0] rom_addr;
    logic [UW-1:0] rom_data;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [UW-3:0] ctrl_word;
    logic          array_done;
    logic          flush;
    logic          busy;
    logic          instr_done;

    typedef struct {
        logic [UA-1:0] addr;
        logic [UW-3:0] word;
    } exp_t;

    exp_t          sb[$];
    logic [UW-1:0] rom [2**UA];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            done_count = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    microcode_sequencer #(.UADDR_W(UA), .UWORD_W(UW)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .opcode       (opcode),
        .function4bit (function4bit),
        .function5bit (function5bit),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .ctrl_word    (ctrl_word),
        .array_done   (array_done),
        .flush        (flush),
        .busy         (busy),
        .instr_done   (instr_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [UW-1:0] mk_word(input logic eor, input logic wt);
        logic [UW-1:0] w;
        w           = UW'($urandom);
        w[EOR_BIT]  = eor;
        w[WAIT_BIT] = wt;
        return w;
    endfunction

    task automatic push(input logic [UA-1:0] a);
        exp_t e;
        e.addr = a;
        e.word = rom[a][UW-3:0];
        sb.push_back(e);
    endtask

    task automatic send_instr(input logic [3:0] op, input logic [3:0] f4, input logic [4:0] f5);
        check("instr_ready_pre", instr_ready, 1'b1);
        opcode       = op;
        function4bit = f4;
        function5bit = f5;
        instr_valid  = 1'b1;
        tick();
        instr_valid  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        while (!instr_done && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    // One-word routine from a mapped entry; optionally with flush held
    // during the accept cycle (a no-op in IDLE).
    task automatic run_one(input logic [3:0] op, input logic [3:0] f4, input logic [4:0] f5,
                           input logic [UA-1:0] exp_addr, input logic with_flush);
        int c;
        rom[exp_addr] = mk_word(1'b1, 1'b0);
        push(exp_addr);
        flush = with_flush;
        send_instr(op, f4, f5);
        flush = 1'b0;
        check("map_fetch_addr", rom_addr, exp_addr);
        check("map_busy", busy, 1'b1);
        wait_done(10, c);
        check("one_word_latency", c, 2);
        tick();
        check("done_one_cycle", instr_done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    // Scoreboard side: every accepted control word must match the next entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ctrl_valid && ctrl_ready && !flush) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ctrl_addr", rom_addr, e.addr);
                check("ctrl_word", ctrl_word, e.word);
            end
        end
        if (instr_done) done_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int            c;
        int            dc0;
        logic [UW-3:0] held;

        for (int i = 0; i < 2**UA; i++) rom[i] = '0;
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; function4bit = '0;
        function5bit = '0; ctrl_ready = 1'b1; array_done = 1'b0; flush = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl_valid", ctrl_valid, 1'b0);
        check("rst_instr_done", instr_done, 1'b0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_ctrl_word", ctrl_word, 0);
        rst = 1'b0;
        tick();
        check("rst_instr_ready", instr_ready, 1'b1);

        // Entry address map.
        run_one(4'h6, 4'd3, 5'd0,  8'h09, 1'b0);
        run_one(4'h9, 4'd0, 5'd31, 8'h75, 1'b0);
        run_one(4'h3, 4'd0, 5'd0,  8'h03, 1'b1);
        run_one(4'h8, 4'd0, 5'd0,  8'h36, 1'b0);

        // Three-word routine at N=2.
        rom[2] = mk_word(1'b0, 1'b0); push(2);
        rom[3] = mk_word(1'b0, 1'b0); push(3);
        rom[4] = mk_word(1'b1, 1'b0); push(4);
        send_instr(4'h2, 4'd0, 5'd0);
        wait_done(20, c);
        check("three_word_latency", c, 6);
        tick();
        check("three_word_busy_after", busy, 1'b0);
        check("three_word_ready_after", instr_ready, 1'b1);

        // Backpressure: hold ISSUE for 4 cycles.
        rom[4] = mk_word(1'b0, 1'b0); push(4);
        rom[5] = mk_word(1'b1, 1'b0); push(5);
        ctrl_ready = 1'b0;
        send_instr(4'h4, 4'd0, 5'd0);
        tick();
        held = rom[4][UW-3:0];
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", ctrl_valid, 1'b1);
            check("bp_word_stable", ctrl_word, held);
            check("bp_upc_stable", rom_addr, 8'h04);
            tick();
        end
        ctrl_ready = 1'b1;
        wait_done(10, c);
        check("bp_resume_latency", c, 3);
        tick();

        // Stall on a wait word; array_done during FETCH must be ignored.
        rom[5] = mk_word(1'b0, 1'b1); push(5);
        rom[6] = mk_word(1'b1, 1'b0); push(6);
        send_instr(4'h5, 4'd0, 5'd0);
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_low", ctrl_valid, 1'b0);
            check("stall_upc_hold", rom_addr, 8'h05);
            check("stall_busy", busy, 1'b1);
            tick();
        end
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("stall_advance", rom_addr, 8'h06);
        wait_done(10, c);
        check("stall_tail_latency", c, 2);
        tick();

        // array_done coincident with the handshake skips WAIT.
        rom[5] = mk_word(1'b0, 1'b1); push(5);
        rom[6] = mk_word(1'b1, 1'b0); push(6);
        send_instr(4'h5, 4'd0, 5'd0);
        tick();
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("skip_wait_addr", rom_addr, 8'h06);
        tick();
        check("skip_wait_issue", ctrl_valid, 1'b1);
        wait_done(10, c);
        check("skip_wait_latency", c, 1);
        tick();

        // Flush while in WAIT.
        rom[5] = mk_word(1'b0, 1'b1); push(5);
        rom[6] = mk_word(1'b1, 1'b0);
        send_instr(4'h5, 4'd0, 5'd0);
        tick();
        tick();
        dc0   = done_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_ready", instr_ready, 1'b1);
        check("flush_valid", ctrl_valid, 1'b0);
        check("flush_upc_kept", rom_addr, 8'h05);
        array_done = 1'b1;
        tick();
        array_done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("flush_no_done", done_count, dc0);
        check("flush_idle_busy", busy, 1'b0);

        // Asynchronous reset mid-ISSUE.
        rom[4] = mk_word(1'b0, 1'b0);
        ctrl_ready = 1'b0;
        send_instr(4'h4, 4'd0, 5'd0);
        tick();
        check("pre_rst_valid", ctrl_valid, 1'b1);
        dc0 = done_count;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", ctrl_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_ctrl_word", ctrl_word, 0);
        check("arst_instr_done", instr_done, 1'b0);
        tick();
        rst        = 1'b0;
        ctrl_ready = 1'b1;
        tick();
        check("arst_ready_after", instr_ready, 1'b1);
        check("arst_no_done", done_count, dc0);

        // upc wrap: walk 0x75..0xFF then 0x00 (eor).
        for (int a = 8'h75; a <= 8'hFF; a++) begin
            rom[a] = mk_word(1'b0, 1'b0);
            push(UA'(a));
        end
        rom[0] = mk_word(1'b1, 1'b0);
        push(0);
        send_instr(4'h9, 4'd0, 5'd31);
        check("wrap_entry", rom_addr, 8'h75);
        wait_done(400, c);
        check("wrap_latency", c, 280);
        check("wrap_final_addr", rom_addr, 8'h00);
        tick();
        tick();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
